rs485_addr_responder: RTL and testbench

Half-duplex RS-485 slave endpoint for the POEM/PSLV link. It receives 11-bit frames on rx: start, 8 data bits LSB-first, mode bit, stop. When an address frame (mode=1) matches SLAVE_ADDR, it drives the bus and sends a RESP_BYTES-long response in the same frame format, with mode=0.
It supersedes the fixed 2-byte, clock-per-bit responder with:
- parametrised baud rate, address and response length;
- mid-bit sampling;
- framing-error detection;
- a bus turnaround delay.

---
 rtl/rs485_pkg.sv | 31 +++
 rtl/rs485_frame_rx.sv | 143 ++++++++++++++
 rtl/rs485_addr_responder.sv | 206 ++++++++++++++++++++
 tb/tb_rs485_addr_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rs485_pkg.sv
// Shared definitions for the RS-485 address responder: frame constants,
// RX/TX state encodings and the response checksum helper.
package rs485_pkg;

    localparam int   FRAME_BITS = 11;
    localparam logic MODE_ADDR  = 1'b1;
    localparam logic MODE_DATA  = 1'b0;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_MODE,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_TURN,
        TX_START,
        TX_DATA,
        TX_MODE,
        TX_STOP
    } tx_state_t;

    // One accumulation step of the mod-256 response checksum.
    function automatic logic [7:0] checksum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/rs485_frame_rx.sv
// RS-485 frame receiver: 2-flop synchroniser, falling-edge start detect,
// mid-bit sampling of start/8 data (LSB first)/mode/stop.
// frame_valid / frame_err pulse the cycle after the stop bit is sampled.
//
// state    | meaning
// ---------+--------------------------------------------------------
// RX_IDLE  | waiting for a synced 1->0 edge (also forced while hold)
// RX_START | timing half a bit to re-check the start bit
// RX_DATA  | sampling 8 data bits, one per bit period
// RX_MODE  | sampling the mode bit
// RX_STOP  | sampling the stop bit, then flag valid or framing error
module rs485_frame_rx
    import rs485_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       hold,
    output logic [7:0] data_byte,
    output logic       mode,
    output logic       frame_valid,
    output logic       frame_err
);

    localparam int              TMR_W    = $clog2(CLKS_PER_BIT);
    localparam logic [TMR_W-1:0] TMR_FULL = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]       IDX_LAST = 4'(FRAME_BITS - 4);

    logic             rx_meta, rx_sync, rx_prev;
    rx_state_t        state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [3:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shift, shift_nxt;
    logic             mode_nxt, valid_nxt, err_nxt;
    logic             tick;

    assign tick      = (timer == '0);
    assign data_byte = shift;

    // Synchronise rx and keep the previous synced value for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // State, bit timer, bit index, shift register and result pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RX_IDLE;
            timer       <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            mode        <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            bit_idx     <= bit_idx_nxt;
            shift       <= shift_nxt;
            mode        <= mode_nxt;
            frame_valid <= valid_nxt;
            frame_err   <= err_nxt;
        end
    end

    // Next-state logic; the down-counting timer samples a bit at terminal count.
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        mode_nxt    = mode;
        valid_nxt   = 1'b0;
        err_nxt     = 1'b0;
        if (state != RX_IDLE && !tick) begin
            timer_nxt = timer - TMR_W'(1);
        end
        case (state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    state_nxt = RX_START;
                    timer_nxt = TMR_HALF;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rx_sync) begin
                        state_nxt = RX_IDLE;
                    end else begin
                        state_nxt   = RX_DATA;
                        timer_nxt   = TMR_FULL;
                        bit_idx_nxt = '0;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    shift_nxt = {rx_sync, shift[7:1]};
                    timer_nxt = TMR_FULL;
                    if (bit_idx == IDX_LAST) begin
                        state_nxt = RX_MODE;
                    end else begin
                        bit_idx_nxt = bit_idx + 4'd1;
                    end
                end
            end
            RX_MODE: begin
                if (tick) begin
                    mode_nxt  = rx_sync;
                    timer_nxt = TMR_FULL;
                    state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (tick) begin
                    state_nxt = RX_IDLE;
                    if (rx_sync) begin
                        valid_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
        // The link is half duplex: ignore the line while we are responding.
        if (hold) begin
            state_nxt = RX_IDLE;
        end
    end

endmodule

// File: rtl/rs485_addr_responder.sv
// Half-duplex RS-485 slave endpoint. Answers an address frame matching
// SLAVE_ADDR with RESP_BYTES data frames (mode=0) after a turnaround delay.
// Optional build macro RS485_RESP_CHECKSUM_EN appends a mod-256 sum byte.
//
// state    | meaning
// ---------+--------------------------------------------------------
// TX_IDLE  | bus released, waiting for addr_match
// TX_TURN  | driver enabled, line held high for the turnaround bits
// TX_START | sending start bit (0)
// TX_DATA  | sending 8 data bits LSB first
// TX_MODE  | sending mode bit (data mode, 0)
// TX_STOP  | sending stop bit (1), then next byte or finish
module rs485_addr_responder
    import rs485_pkg::*;
#(
    parameter int          CLKS_PER_BIT    = 16,
    parameter logic [7:0]  SLAVE_ADDR      = 8'h01,
    parameter int          RESP_BYTES      = 2,
    parameter int          TURNAROUND_BITS = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx,
    input  logic [8*RESP_BYTES-1:0] resp_data,
    output logic                    tx,
    output logic                    tx_en,
    output logic                    busy,
    output logic                    addr_match,
    output logic                    frame_err,
    output logic                    tx_done
);

`ifdef RS485_RESP_CHECKSUM_EN
    localparam int NB = RESP_BYTES + 1;
`else
    localparam int NB = RESP_BYTES;
`endif
    localparam int               TMR_W     = $clog2(CLKS_PER_BIT);
    localparam int               BYTE_W    = $clog2(RESP_BYTES + 2);
    localparam int               BUF_N     = 1 << BYTE_W;
    localparam logic [TMR_W-1:0]  TMR_FULL  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        IDX_LAST  = 4'(FRAME_BITS - 4);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NB - 1);

    logic [7:0]        rx_byte;
    logic              rx_mode, rx_valid;
    tx_state_t         state, state_nxt;
    logic [TMR_W-1:0]  timer, timer_nxt;
    logic [3:0]        bit_idx, idx_nxt;
    logic [BYTE_W-1:0] byte_cnt, byte_nxt;
    logic              done_nxt, tick;
    logic [7:0]        latch_bytes [BUF_N];
    logic [7:0]        tx_bytes    [BUF_N];
    logic [7:0]        cur_byte;
`ifdef RS485_RESP_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    rs485_frame_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_frame_rx (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .hold        (busy),
        .data_byte   (rx_byte),
        .mode        (rx_mode),
        .frame_valid (rx_valid),
        .frame_err   (frame_err)
    );

    assign addr_match = rx_valid && (rx_mode == MODE_ADDR) && (rx_byte == SLAVE_ADDR);
    assign tx_en      = (state != TX_IDLE);
    assign busy       = tx_en;
    assign tick       = (timer == '0);

    // Response bytes as they would be captured now; unused slots stay zero.
    always_comb begin
        for (int i = 0; i < BUF_N; i++) begin
            latch_bytes[i] = 8'h00;
        end
        for (int i = 0; i < RESP_BYTES; i++) begin
            latch_bytes[i] = resp_data[i*8 +: 8];
        end
`ifdef RS485_RESP_CHECKSUM_EN
        csum = 8'h00;
        for (int i = 0; i < RESP_BYTES; i++) begin
            csum = checksum_add(csum, resp_data[i*8 +: 8]);
        end
        latch_bytes[RESP_BYTES] = csum;
`endif
    end

    // Freeze the payload on addr_match so later resp_data edits don't leak in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BUF_N; i++) begin
                tx_bytes[i] <= 8'h00;
            end
        end else if (addr_match) begin
            tx_bytes <= latch_bytes;
        end
    end

    // TX state register and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= TX_IDLE;
            timer    <= '0;
            bit_idx  <= '0;
            byte_cnt <= '0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            bit_idx  <= idx_nxt;
            byte_cnt <= byte_nxt;
            tx_done  <= done_nxt;
        end
    end

    // TX next-state: every bit (turnaround included) is one full timer period.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        idx_nxt   = bit_idx;
        byte_nxt  = byte_cnt;
        done_nxt  = 1'b0;
        if (state != TX_IDLE && !tick) begin
            timer_nxt = timer - TMR_W'(1);
        end
        case (state)
            TX_IDLE: begin
                if (addr_match) begin
                    timer_nxt = TMR_FULL;
                    byte_nxt  = '0;
                    if (TURNAROUND_BITS > 0) begin
                        state_nxt = TX_TURN;
                        idx_nxt   = 4'(TURNAROUND_BITS - 1);
                    end else begin
                        state_nxt = TX_START;
                    end
                end
            end
            TX_TURN: begin
                if (tick) begin
                    timer_nxt = TMR_FULL;
                    if (bit_idx == 4'd0) begin
                        state_nxt = TX_START;
                    end else begin
                        idx_nxt = bit_idx - 4'd1;
                    end
                end
            end
            TX_START: begin
                if (tick) begin
                    timer_nxt = TMR_FULL;
                    idx_nxt   = '0;
                    state_nxt = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tick) begin
                    timer_nxt = TMR_FULL;
                    if (bit_idx == IDX_LAST) begin
                        state_nxt = TX_MODE;
                    end else begin
                        idx_nxt = bit_idx + 4'd1;
                    end
                end
            end
            TX_MODE: begin
                if (tick) begin
                    timer_nxt = TMR_FULL;
                    state_nxt = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (byte_cnt == LAST_BYTE) begin
                        state_nxt = TX_IDLE;
                        byte_nxt  = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        byte_nxt  = byte_cnt + BYTE_W'(1);
                        timer_nxt = TMR_FULL;
                        state_nxt = TX_START;
                    end
                end
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

    // Line level follows the current state; idle and turnaround are high.
    always_comb begin
        cur_byte = tx_bytes[byte_cnt];
        case (state)
            TX_START: tx = 1'b0;
            TX_DATA:  tx = cur_byte[bit_idx[2:0]];
            TX_MODE:  tx = MODE_DATA;
            default:  tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_rs485_addr_responder.sv
// Randomised self-checking bench for rs485_addr_responder. Expected line
// activity is derived from the frame format (bit positions in time), not
// from the design's state machines.
module tb_rs485_addr_responder;

    localparam int         CPB  = 16;
    localparam int         RB   = 2;
    localparam int         TB   = 1;
    localparam logic [7:0] ADDR = 8'h01;
    localparam int         RW   = 8 * RB;
`ifdef RS485_RESP_CHECKSUM_EN
    localparam int NB = RB + 1;
`else
    localparam int NB = RB;
`endif
    localparam int EN_LEN = (TB + 11 * NB) * CPB;

    logic          clk = 1'b0;
    logic          reset, rx;
    logic [RW-1:0] resp_data;
    logic          tx, tx_en, busy, addr_match, frame_err, tx_done;

    always #5 clk = ~clk;

    rs485_addr_responder #(
        .CLKS_PER_BIT    (CPB),
        .SLAVE_ADDR      (ADDR),
        .RESP_BYTES      (RB),
        .TURNAROUND_BITS (TB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .resp_data  (resp_data),
        .tx         (tx),
        .tx_en      (tx_en),
        .busy       (busy),
        .addr_match (addr_match),
        .frame_err  (frame_err),
        .tx_done    (tx_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observed bus activity, accumulated by the monitor.
    int   n_match, n_ferr, n_done, n_rise, en_len, last_en_len, busy_bad, idle_bad;
    bit   done_at_fall, rise_after_match, prev_en, prev_match;
    bit   tx_q[$];
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (addr_match) n_match++;
        if (frame_err) n_ferr++;
        if (tx_done) n_done++;
        if (busy !== tx_en) busy_bad++;
        if (tx_en) begin
            if (!prev_en) begin
                n_rise++;
                rise_after_match = prev_match;
            end
            en_len++;
            tx_q.push_back(tx);
        end else begin
            if (tx !== 1'b1) idle_bad++;
            if (prev_en) begin
                last_en_len  = en_len;
                done_at_fall = tx_done;
            end
            en_len = 0;
        end
        prev_en    = tx_en;
        prev_match = addr_match;
    end

    task automatic clear_counts();
        @(posedge clk);
        n_match = 0; n_ferr = 0; n_done = 0; n_rise = 0;
        last_en_len = 0; busy_bad = 0; idle_bad = 0;
        done_at_fall = 0; rise_after_match = 0;
        tx_q.delete();
    endtask

    // Reference: the bytes a correct response must carry.
    task automatic build_model(input logic [RW-1:0] r);
        int sum;
        sum = 0;
        exp_q.delete();
        for (int k = 0; k < RB; k++) begin
            exp_q.push_back(r[8*k +: 8]);
            sum += int'(r[8*k +: 8]);
        end
`ifdef RS485_RESP_CHECKSUM_EN
        exp_q.push_back(8'(sum % 256));
`endif
    endtask

    // Reference: expected tx level j cycles after tx_en rises.
    function automatic bit exp_bit(int j);
        int p, pos;
        logic [7:0] b;
        if (j < TB * CPB) return 1'b1;
        p   = (j - TB * CPB) / CPB;
        pos = p % 11;
        b   = exp_q[p / 11];
        if (pos == 0 || pos == 9) return 1'b0;
        if (pos == 10) return 1'b1;
        return b[pos - 1];
    endfunction

    task automatic send_frame(input logic [7:0] d, input bit m, input bit stp);
        logic [10:0] f;
        f = {stp, m, d, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            rx = f[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic settle();
        int k;
        k = 0;
        repeat (20) @(negedge clk);
        while (tx_en && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("settle_tx_en", 32'(tx_en), 32'd0);
        repeat (5) @(negedge clk);
    endtask

    task automatic scenario(input string tag, input logic [7:0] d, input bit m, input bit stp,
                            input bit exp_resp);
        int werr, idx;
        logic [7:0] got;
        clear_counts();
        build_model(resp_data);
        send_frame(d, m, stp);
        resp_data = RW'($urandom);
        settle();
        check({tag, "_match"}, 32'(n_match), 32'(exp_resp));
        check({tag, "_ferr"}, 32'(n_ferr), 32'(!stp));
        check({tag, "_done"}, 32'(n_done), 32'(exp_resp));
        check({tag, "_en_rise"}, 32'(n_rise), 32'(exp_resp));
        check({tag, "_busy_vs_en"}, 32'(busy_bad), 32'd0);
        check({tag, "_idle_tx"}, 32'(idle_bad), 32'd0);
        if (exp_resp) begin
            check({tag, "_en_len"}, 32'(last_en_len), 32'(EN_LEN));
            check({tag, "_q_len"}, 32'(tx_q.size()), 32'(EN_LEN));
            check({tag, "_done_at_fall"}, 32'(done_at_fall), 32'd1);
            check({tag, "_rise_after_match"}, 32'(rise_after_match), 32'd1);
            werr = 0;
            for (int j = 0; j < tx_q.size() && j < EN_LEN; j++) begin
                if (tx_q[j] != exp_bit(j)) werr++;
            end
            check({tag, "_wave"}, 32'(werr), 32'd0);
            for (int k = 0; k < NB; k++) begin
                got = 8'h00;
                for (int i = 0; i < 8; i++) begin
                    idx = TB * CPB + (k * 11 + 1 + i) * CPB + CPB / 2;
                    if (idx < tx_q.size()) got[i] = tx_q[idx];
                end
                check($sformatf("%s_byte%0d", tag, k), 32'(got), 32'(exp_q[k]));
            end
        end
    endtask

    initial begin
        logic [7:0] a;
        int sel;
        reset     = 1'b1;
        rx        = 1'b1;
        resp_data = 16'h3F0A;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_tx_en", 32'(tx_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr_match", 32'(addr_match), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_tx_done", 32'(tx_done), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        scenario("basic", ADDR, 1'b1, 1'b1, 1'b1);
        scenario("wrong_addr", 8'h02, 1'b1, 1'b1, 1'b0);
        scenario("data_frame", ADDR, 1'b0, 1'b1, 1'b0);
        scenario("stop_err", ADDR, 1'b1, 1'b0, 1'b0);
        scenario("after_err", ADDR, 1'b1, 1'b1, 1'b1);

        // Short low glitch must be rejected at the start-bit re-check.
        clear_counts();
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch_match", 32'(n_match), 32'd0);
        check("glitch_ferr", 32'(n_ferr), 32'd0);
        scenario("after_glitch", ADDR, 1'b1, 1'b1, 1'b1);

        // Abort a response during byte 1 data bits.
        clear_counts();
        send_frame(ADDR, 1'b1, 1'b1);
        repeat (240) @(negedge clk);
        check("pre_reset_en", 32'(tx_en), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_tx", 32'(tx), 32'd1);
        check("async_rst_tx_en", 32'(tx_en), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        scenario("after_reset", ADDR, 1'b1, 1'b1, 1'b1);

        for (int it = 0; it < 8; it++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: begin
                    resp_data = RW'($urandom);
                    scenario($sformatf("rnd%0d_match", it), ADDR, 1'b1, 1'b1, 1'b1);
                end
                1: begin
                    a = 8'($urandom);
                    if (a == ADDR) a = a ^ 8'h80;
                    scenario($sformatf("rnd%0d_other", it), a, 1'b1, 1'b1, 1'b0);
                end
                2: begin
                    a = 8'($urandom);
                    scenario($sformatf("rnd%0d_data", it), a, 1'b0, 1'b1, 1'b0);
                end
                default: begin
                    scenario($sformatf("rnd%0d_ferr", it), ADDR, 1'b1, 1'b0, 1'b0);
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
